pipemwstage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register for the pipelined CPU. It consumes the EX/MEM register outputs and runs a request/acknowledge transaction to data memory for loads and stores. While an access is outstanding it freezes the upstream pipeline and injects bubbles into writeback. It then presents the completed result to the WB stage.

---
 rtl/pipemwstage_if.sv | 19 +
 rtl/pipemwstage.sv | 173 +++++++++++++++++
 tb/tb_pipemwstage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipemwstage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface pipemwstage_if;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] drdata;
    logic        dack;

    modport master (
        output dreq, dwe, daddr, dwdata,
        input  drdata, dack
    );

    modport slave (
        input  dreq, dwe, daddr, dwdata,
        output drdata, dack
    );
endinterface

// File: rtl/pipemwstage.sv
// MEM stage with data-memory handshake, timeout abort and the MEM/WB pipeline register.
// Stalls upstream and bubbles writeback while a load/store is outstanding.
module pipemwstage #(
    parameter int unsigned MAXWAIT = 15
) (
    input  logic                 clk,
    input  logic                 clrn,
    pipemwstage_if.master        dmem,
    input  logic                 mwreg_i,
    input  logic                 mm2reg_i,
    input  logic                 mwmem_i,
    input  logic [31:0]          malu_i,
    input  logic [31:0]          mb_i,
    input  logic [4:0]           mrn_i,
    output logic                 mstall_o,
    output logic                 merr_o,
    output logic                 wwreg_o,
    output logic                 wm2reg_o,
    output logic [31:0]          wmo_o,
    output logic [31:0]          walu_o,
    output logic [4:0]           wrn_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAXWAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dreq_q, dreq_d;
    logic        dwe_q, dwe_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        merr_q, merr_d;
    logic        wwreg_q, wwreg_d;
    logic        wm2reg_q, wm2reg_d;
    logic [31:0] wmo_q, wmo_d;
    logic [31:0] walu_q, walu_d;
    logic [4:0]  wrn_q, wrn_d;

    logic        memop_s;
    logic        mstall_s;

    assign memop_s  = mm2reg_i | mwmem_i;
    assign mstall_s = ((state_q == ST_IDLE) & memop_s) | (state_q == ST_WAIT);

    // State, memory-bus and MEM/WB registers
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= 32'd0;
            dwdata_q <= 32'd0;
            rbuf_q   <= 32'd0;
            merr_q   <= 1'b0;
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wmo_q    <= 32'd0;
            walu_q   <= 32'd0;
            wrn_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dreq_q   <= dreq_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            rbuf_q   <= rbuf_d;
            merr_q   <= merr_d;
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wmo_q    <= wmo_d;
            walu_q   <= walu_d;
            wrn_q    <= wrn_d;
        end
    end

    // Handshake FSM next state; bus fields are zeroed whenever the request drops
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dreq_d   = dreq_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        rbuf_d   = rbuf_q;
        merr_d   = merr_q;
        case (state_q)
            ST_IDLE: begin
                if (memop_s) begin
                    dreq_d   = 1'b1;
                    dwe_d    = mwmem_i;
                    daddr_d  = malu_i;
                    dwdata_d = mb_i;
                    cnt_d    = 8'd0;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // An acknowledge in the final wait cycle still completes normally
                if (dmem.dack) begin
                    rbuf_d   = dwe_q ? 32'd0 : dmem.drdata;
                    dreq_d   = 1'b0;
                    dwe_d    = 1'b0;
                    daddr_d  = 32'd0;
                    dwdata_d = 32'd0;
                    state_d  = ST_DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    rbuf_d   = 32'd0;
                    merr_d   = 1'b1;
                    dreq_d   = 1'b0;
                    dwe_d    = 1'b0;
                    daddr_d  = 32'd0;
                    dwdata_d = 32'd0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                dreq_d   = 1'b0;
                dwe_d    = 1'b0;
                daddr_d  = 32'd0;
                dwdata_d = 32'd0;
            end
        endcase
    end

    // MEM/WB register: bubble while stalled, otherwise take the completed op
    always_comb begin
        wwreg_d  = wwreg_q;
        wm2reg_d = wm2reg_q;
        wmo_d    = wmo_q;
        walu_d   = walu_q;
        wrn_d    = wrn_q;
        if (mstall_s) begin
            wwreg_d  = 1'b0;
            wm2reg_d = 1'b0;
        end else begin
            wwreg_d  = mwreg_i;
            wm2reg_d = mm2reg_i & ~mwmem_i;
            walu_d   = malu_i;
            wrn_d    = mrn_i;
            wmo_d    = (state_q == ST_DONE) ? rbuf_q : 32'd0;
        end
    end

    assign dmem.dreq   = dreq_q;
    assign dmem.dwe    = dwe_q;
    assign dmem.daddr  = daddr_q;
    assign dmem.dwdata = dwdata_q;
    assign mstall_o    = mstall_s;
    assign merr_o      = merr_q;
    assign wwreg_o     = wwreg_q;
    assign wm2reg_o    = wm2reg_q;
    assign wmo_o       = wmo_q;
    assign walu_o      = walu_q;
    assign wrn_o       = wrn_q;

endmodule

// File: tb/tb_pipemwstage.sv
// Bench for pipemwstage: directed cases followed by random ops checked against a per-transaction timing model.
module tb_pipemwstage;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        mstall, merr, wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    int   checks = 0;
    int   errors = 0;
    logic model_merr;

    pipemwstage_if dbus ();

    pipemwstage #(.MAXWAIT(MAXW)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .dmem     (dbus),
        .mwreg_i  (mwreg),
        .mm2reg_i (mm2reg),
        .mwmem_i  (mwmem),
        .malu_i   (malu),
        .mb_i     (mb),
        .mrn_i    (mrn),
        .mstall_o (mstall),
        .merr_o   (merr),
        .wwreg_o  (wwreg),
        .wm2reg_o (wm2reg),
        .wmo_o    (wmo),
        .walu_o   (walu),
        .wrn_o    (wrn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wr, input logic m2, input logic wm,
                          input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
        mwreg = wr; mm2reg = m2; mwmem = wm; malu = alu; mb = b; mrn = rn;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    // One instruction through MEM. k = WAIT cycle carrying dack (1-based); k outside 1..MAXW means no dack.
    task automatic run_op(input logic wr, input logic m2, input logic wm,
                          input logic [31:0] alu, input logic [31:0] b,
                          input logic [31:0] rd, input logic [4:0] rn, input int k);
        bit          memop;
        bit          tmo;
        int          nw;
        logic [31:0] exp_wmo;
        memop = m2 | wm;
        set_in(wr, m2, wm, alu, b, rn);
        dbus.dack = 1'b0;
        if (!memop) begin
            @(negedge clk);
            chk("nop_mstall", mstall, 32'd0);
            chk("nop_dreq", dbus.dreq, 32'd0);
            tick();
            exp_wmo = 32'd0;
        end else begin
            tmo = (k < 1) || (k > MAXW);
            nw  = tmo ? MAXW : k;
            dbus.dack   = 1'($urandom_range(0, 1));
            dbus.drdata = $urandom();
            @(negedge clk);
            chk("idle_mstall", mstall, 32'd1);
            chk("idle_dreq", dbus.dreq, 32'd0);
            tick();
            for (int w = 1; w <= nw; w++) begin
                dbus.dack   = (w == k);
                dbus.drdata = (w == k) ? rd : $urandom();
                @(negedge clk);
                chk("wait_mstall", mstall, 32'd1);
                chk("wait_dreq", dbus.dreq, 32'd1);
                chk("wait_dwe", dbus.dwe, 32'(wm));
                chk("wait_daddr", dbus.daddr, alu);
                chk("wait_dwdata", dbus.dwdata, b);
                chk("wait_wwreg", wwreg, 32'd0);
                chk("wait_wm2reg", wm2reg, 32'd0);
                chk("wait_merr", merr, 32'(model_merr));
                tick();
            end
            if (tmo) model_merr = 1'b1;
            dbus.dack   = 1'($urandom_range(0, 1));
            dbus.drdata = $urandom();
            @(negedge clk);
            chk("done_mstall", mstall, 32'd0);
            chk("done_dreq", dbus.dreq, 32'd0);
            chk("done_dwe", dbus.dwe, 32'd0);
            chk("done_daddr", dbus.daddr, 32'd0);
            chk("done_dwdata", dbus.dwdata, 32'd0);
            chk("done_merr", merr, 32'(model_merr));
            chk("done_wwreg", wwreg, 32'd0);
            tick();
            exp_wmo = (tmo || wm) ? 32'd0 : rd;
        end
        idle_in();
        dbus.dack = 1'b0;
        @(negedge clk);
        chk("wb_wwreg", wwreg, 32'(wr));
        chk("wb_wm2reg", wm2reg, 32'(m2 & ~wm));
        chk("wb_wmo", wmo, exp_wmo);
        chk("wb_walu", walu, alu);
        chk("wb_wrn", wrn, 32'(rn));
        chk("wb_merr", merr, 32'(model_merr));
        tick();
    endtask

    initial begin
        logic m2, wm;
        int   k;
        model_merr  = 1'b0;
        dbus.dack   = 1'b0;
        dbus.drdata = 32'd0;

        // Reset with random inputs including a load
        clrn = 1'b1;
        set_in(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
               $urandom(), $urandom(), 5'($urandom_range(0, 31)));
        dbus.dack = 1'b1;
        dbus.drdata = $urandom();
        #3;
        chk("rst_dreq", dbus.dreq, 32'd0);
        chk("rst_dwe", dbus.dwe, 32'd0);
        chk("rst_daddr", dbus.daddr, 32'd0);
        chk("rst_dwdata", dbus.dwdata, 32'd0);
        chk("rst_merr", merr, 32'd0);
        chk("rst_wwreg", wwreg, 32'd0);
        chk("rst_wm2reg", wm2reg, 32'd0);
        chk("rst_wmo", wmo, 32'd0);
        chk("rst_walu", walu, 32'd0);
        chk("rst_wrn", wrn, 32'd0);
        chk("rst_mstall_memop", mstall, 32'd1);
        tick();
        chk("rst_hold_dreq", dbus.dreq, 32'd0);
        chk("rst_hold_walu", walu, 32'd0);
        idle_in();
        dbus.dack = 1'b0;
        #1;
        chk("rst_mstall_nop", mstall, 32'd0);
        tick();
        clrn = 1'b0;

        // ALU op, load with dack in 2nd WAIT, store with dack in 1st WAIT
        run_op(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd7, 2);
        run_op(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h1111_2222, 5'd3, 1);
        // Store and load flags together: store wins
        run_op(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h5555_AAAA, 32'h7777_8888, 5'd9, 3);
        // dack in the last allowed WAIT cycle beats the timeout
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 5'd0, MAXW);
        // Timeout, then a normal op with merr still set
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'hFFFF_FFFF, 5'd12, 0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'hA5A5_5A5A, 5'd13, 1);

        // Reset in the middle of WAIT, then a late dack
        set_in(1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 5'd14);
        tick();
        tick();
        #2;
        clrn = 1'b1;
        #1;
        model_merr = 1'b0;
        chk("midrst_dreq", dbus.dreq, 32'd0);
        chk("midrst_daddr", dbus.daddr, 32'd0);
        chk("midrst_merr", merr, 32'd0);
        chk("midrst_wwreg", wwreg, 32'd0);
        idle_in();
        tick();
        clrn = 1'b0;
        dbus.dack = 1'b1;
        dbus.drdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("late_mstall", mstall, 32'd0);
        chk("late_dreq", dbus.dreq, 32'd0);
        tick();
        dbus.dack = 1'b0;
        @(negedge clk);
        chk("late_dreq2", dbus.dreq, 32'd0);
        chk("late_wwreg", wwreg, 32'd0);
        chk("late_wmo", wmo, 32'd0);
        chk("late_merr", merr, 32'd0);
        tick();

        // Random ops
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       begin m2 = 1'b0; wm = 1'b0; end
                1:       begin m2 = 1'b1; wm = 1'b0; end
                2:       begin m2 = 1'b0; wm = 1'b1; end
                default: begin m2 = 1'b1; wm = 1'b1; end
            endcase
            k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAXW));
            run_op(1'($urandom_range(0, 1)), m2, wm, $urandom(), $urandom(), $urandom(),
                   5'($urandom_range(0, 31)), k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
